// File: rtl/dccm_ctrl.sv
// DCCM responder for the LSU. It has one combinational read port, one write port,
// a power-on/requested clear FSM, and a sticky first-error capture register.
module dccm_ctrl #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dccm_wr_en_i,
    input  logic        dccm_rd_en_i,
    input  logic [31:0] dccm_wr_addr_i,
    input  logic [31:0] dccm_rd_addr_i,
    input  logic [31:0] dccm_wr_data_i,
    output logic [31:0] dccm_rd_data_o,
    input  logic        dccm_clr_req_i,
    output logic        dccm_busy_o,
    output logic        dccm_err_o,
    output logic [1:0]  dccm_err_cause_o,
    output logic [31:0] dccm_err_addr_o,
    input  logic        dccm_err_clr_i
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_RANGE = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;
    localparam logic [1:0] CAUSE_BUSY  = 2'b11;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic [AW-1:0]     w_clr_cnt_nxt;
    logic              w_busy;
    logic              w_clr_we;

    logic [31:0]       r_mem [DEPTH];

    logic [1:0]        w_wr_cause;
    logic [1:0]        w_rd_cause;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_wr_err;
    logic              w_rd_err;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;
    logic              w_new_err;
    logic [1:0]        w_new_cause;
    logic [31:0]       w_new_addr;

    logic              r_err;
    logic [1:0]        r_err_cause;
    logic [31:0]       r_err_addr;

    // Priority: busy, then out-of-range, then misaligned.
    function automatic logic [1:0] access_cause(input logic busy, input logic [31:0] addr);
        if (busy)
            return CAUSE_BUSY;
        else if (addr[31:AW+2] != BASE_ADDR[31:AW+2])
            return CAUSE_RANGE;
        else if (addr[1:0] != 2'b00)
            return CAUSE_ALIGN;
        else
            return CAUSE_NONE;
    endfunction

    // Clear FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear FSM: next state. A clear request while clearing is ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt   = S_READY;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_READY: begin
                if (dccm_clr_req_i) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        if (r_state == S_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
        end
    end

    assign w_wr_cause = access_cause(w_busy, dccm_wr_addr_i);
    assign w_rd_cause = access_cause(w_busy, dccm_rd_addr_i);
    assign w_wr_idx   = dccm_wr_addr_i[AW+1:2];
    assign w_rd_idx   = dccm_rd_addr_i[AW+1:2];
    assign w_wr_ok    = dccm_wr_en_i && (w_wr_cause == CAUSE_NONE);
    assign w_rd_ok    = dccm_rd_en_i && (w_rd_cause == CAUSE_NONE);
    assign w_wr_err   = dccm_wr_en_i && (w_wr_cause != CAUSE_NONE);
    assign w_rd_err   = dccm_rd_en_i && (w_rd_cause != CAUSE_NONE);

    // Memory has no reset; the clear FSM owns the write port while busy.
    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_mem[r_clr_cnt] <= '0;
        else if (w_wr_ok)
            r_mem[w_wr_idx] <= dccm_wr_data_i;
    end

    // The LSU samples in the same cycle, so a same-index store is forwarded.
    always_comb begin
        dccm_rd_data_o = '0;
        if (w_rd_ok) begin
            if (w_wr_ok && (w_wr_idx == w_rd_idx))
                dccm_rd_data_o = dccm_wr_data_i;
            else
                dccm_rd_data_o = r_mem[w_rd_idx];
        end
    end

    // The write port is recorded when both ports fault in the same cycle.
    always_comb begin
        w_new_err   = w_wr_err || w_rd_err;
        w_new_cause = w_rd_cause;
        w_new_addr  = dccm_rd_addr_i;
        if (w_wr_err) begin
            w_new_cause = w_wr_cause;
            w_new_addr  = dccm_wr_addr_i;
        end
    end

    // A new error in the same cycle as err_clr is kept rather than cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_err_cause <= CAUSE_NONE;
            r_err_addr  <= '0;
        end else if (w_new_err && (dccm_err_clr_i || !r_err)) begin
            r_err       <= 1'b1;
            r_err_cause <= w_new_cause;
            r_err_addr  <= w_new_addr;
        end else if (dccm_err_clr_i) begin
            r_err       <= 1'b0;
            r_err_cause <= CAUSE_NONE;
            r_err_addr  <= '0;
        end
    end

    assign dccm_busy_o      = w_busy;
    assign dccm_err_o       = r_err;
    assign dccm_err_cause_o = r_err_cause;
    assign dccm_err_addr_o  = r_err_addr;

endmodule
